// File: rtl/disp_sched.sv
// Display scheduler: selects the BCD word and per-digit blank mask shown on the
// 6-digit clock display (time, alarm, stopwatch, edit view or alarm-ring flash).
module disp_sched #(
   parameter int BLINK_HALF = 12_500_000,
   parameter int TO_TICKS   = 40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] time_bcd,
   input  logic [23:0] alarm_bcd,
   input  logic [23:0] sw_bcd,
   input  logic        key_view,
   input  logic        edit_req,
   input  logic        edit_sel,
   input  logic [2:0]  edit_digit,
   input  logic        alarm_ring,
   output logic [23:0] data,
   output logic [5:0]  blank,
   output logic [1:0]  view,
   output logic        edit_ack
);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int TW = $clog2(TO_TICKS + 1);
   localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_HALF - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TO_TICKS);

   typedef enum logic [2:0] {
      S_TIME  = 3'd0,
      S_ALARM = 3'd1,
      S_SW    = 3'd2,
      S_EDIT  = 3'd3,
      S_RING  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [BW-1:0] r_blink_cnt;
   logic          r_phase;        // 1 = digits hidden
   logic [TW-1:0] r_to_cnt;
   logic [2:0]    r_edit_digit;
   logic          w_tick;
   logic          w_timeout;
   logic          w_blink_restart;
   logic [23:0]   w_data;
   logic [5:0]    w_blank;
   logic [1:0]    w_view;
   logic          w_edit_ack;

   assign w_tick    = (r_blink_cnt == BLINK_TC);
   assign w_timeout = (r_to_cnt == TO_MAX);
   // Restarting on entry or digit change makes the edited digit visible at once.
   assign w_blink_restart = ((w_next_state != r_state) &&
                             ((w_next_state == S_EDIT) || (w_next_state == S_RING))) ||
                            ((r_state == S_EDIT) && (edit_digit != r_edit_digit));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_TIME;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (alarm_ring) begin
         w_next_state = S_RING;
      end else if (r_state == S_RING) begin
         w_next_state = edit_req ? S_EDIT : S_TIME;
      end else if (edit_req) begin
         w_next_state = S_EDIT;
      end else if (r_state == S_EDIT) begin
         w_next_state = S_TIME;
      end else begin
         case (r_state)
            S_TIME:  w_next_state = key_view ? S_ALARM : S_TIME;
            S_ALARM: w_next_state = key_view ? S_SW : (w_timeout ? S_TIME : S_ALARM);
            S_SW:    w_next_state = key_view ? S_TIME : S_SW;
            default: w_next_state = S_TIME;
         endcase
      end
   end

   always_comb begin
      w_data     = time_bcd;
      w_blank    = 6'h00;
      w_view     = 2'd0;
      w_edit_ack = 1'b0;
      case (r_state)
         S_TIME: begin
            w_data = time_bcd;
            w_view = 2'd0;
         end
         S_ALARM: begin
            w_data = alarm_bcd;
            w_view = 2'd1;
         end
         S_SW: begin
            w_data = sw_bcd;
            w_view = 2'd2;
         end
         S_EDIT: begin
            w_data     = edit_sel ? alarm_bcd : time_bcd;
            w_view     = 2'd3;
            w_edit_ack = 1'b1;
            if (r_phase && (edit_digit <= 3'd5)) begin
               w_blank = 6'b000001 << edit_digit;
            end else begin
               w_blank = 6'h00;
            end
         end
         S_RING: begin
            w_data  = time_bcd;
            w_view  = 2'd3;
            w_blank = r_phase ? 6'h3F : 6'h00;
         end
         default: begin
            w_data = time_bcd;
            w_view = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data     <= 24'h000000;
         blank    <= 6'h00;
         view     <= 2'd0;
         edit_ack <= 1'b0;
      end else begin
         data     <= w_data;
         blank    <= w_blank;
         view     <= w_view;
         edit_ack <= w_edit_ack;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt  <= '0;
         r_phase      <= 1'b0;
         r_edit_digit <= 3'd0;
      end else begin
         r_edit_digit <= edit_digit;
         if (w_blink_restart) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
         end else if (w_tick) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
         end
      end
   end

   // Alarm-view inactivity counter, counted in blink ticks and saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if ((r_state != S_ALARM) || key_view) begin
         r_to_cnt <= '0;
      end else if (w_tick && !w_timeout) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
         r_to_cnt <= r_to_cnt;
      end
   end
endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: expected output vectors are queued per
// cycle while stimulus is driven and compared on the falling edge.
module tb_disp_sched;
   localparam int BH = 4;
   localparam int TT = 3;
   localparam logic [23:0] T_BCD = 24'h123456;
   localparam logic [23:0] A_BCD = 24'h070000;
   localparam logic [23:0] S_BCD = 24'h012345;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] time_bcd, alarm_bcd, sw_bcd;
   logic        key_view, edit_req, edit_sel, alarm_ring;
   logic [2:0]  edit_digit;
   logic [23:0] data;
   logic [5:0]  blank;
   logic [1:0]  view;
   logic        edit_ack;

   disp_sched #(.BLINK_HALF(BH), .TO_TICKS(TT)) dut (
      .clk(clk), .rst_n(rst_n), .time_bcd(time_bcd), .alarm_bcd(alarm_bcd),
      .sw_bcd(sw_bcd), .key_view(key_view), .edit_req(edit_req), .edit_sel(edit_sel),
      .edit_digit(edit_digit), .alarm_ring(alarm_ring), .data(data), .blank(blank),
      .view(view), .edit_ack(edit_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       tag;
      logic [32:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   bl_base = 0;   // edge after which the blink counter is known to be 0
   int   k, j, t1, t2, t3, r, s, m;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h, want %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [32:0] pk(input logic [23:0] d, input logic [5:0] b,
                                      input logic [1:0] v, input logic a);
      return {d, b, v, a};
   endfunction

   // Blink phase (1 = hidden) after edge x, counted from the last restart.
   function automatic logic hid(input int x);
      return (((x - bl_base) / BH) % 2) == 1;
   endfunction

   function automatic logic [5:0] emask(input int d, input logic h);
      return (h && (d < 6)) ? (6'b000001 << d) : 6'h00;
   endfunction

   function automatic int next_tick(input int after);
      int e = after + 1;
      while (((e - bl_base) % BH) != 0) e++;
      return e;
   endfunction

   task automatic push(input int at, input string nm, input logic [32:0] ev);
      sb_q.push_back('{cyc: at, tag: nm, exp: ev});
   endtask

   task automatic push_run(input int first, input int last, input string nm, input logic [32:0] ev);
      for (int e = first; e <= last; e++) push(e, nm, ev);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_key();
      key_view = 1'b1;
      step(1);
      key_view = 1'b0;
   endtask

   always @(negedge clk) begin
      while ((sb_q.size() > 0) && (sb_q[0].cyc <= cyc)) begin
         if (sb_q[0].cyc == cyc)
            chk(sb_q[0].tag, {data, blank, view, edit_ack}, sb_q[0].exp);
         else
            chk({sb_q[0].tag, "_missed"}, 33'(cyc), 33'(sb_q[0].cyc));
         void'(sb_q.pop_front());
      end
   end

   initial begin
      time_bcd = T_BCD; alarm_bcd = A_BCD; sw_bcd = S_BCD;
      key_view = 1'b0; edit_req = 1'b0; edit_sel = 1'b0;
      edit_digit = 3'd0; alarm_ring = 1'b0;
      step(3);
      chk("reset_hold", {data, blank, view, edit_ack}, 33'h0);
      rst_n = 1'b1;
      bl_base = cyc;
      push_run(cyc + 1, cyc + 4, "time_after_rst", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      step(4);

      // View cycling, key pulses 10 cycles apart
      k = cyc;
      push_run(k + 2, k + 11, "view_alarm", pk(A_BCD, 6'h00, 2'd1, 1'b0));
      pulse_key(); step(9);
      push_run(k + 12, k + 21, "view_sw", pk(S_BCD, 6'h00, 2'd2, 1'b0));
      pulse_key(); step(9);
      push_run(k + 22, k + 25, "view_time", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      pulse_key(); step(5);

      // Alarm view times out after TT ticks
      j = cyc;
      t1 = next_tick(j + 1); t2 = next_tick(t1); t3 = next_tick(t2);
      push_run(j + 2, t3 + 1, "to_alarm", pk(A_BCD, 6'h00, 2'd1, 1'b0));
      push_run(t3 + 2, t3 + 5, "to_time", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      pulse_key();
      step(t3 + 5 - cyc);

      // Key at the second tick advances to SW, which never times out
      j = cyc;
      t1 = next_tick(j + 1); t2 = next_tick(t1);
      push_run(j + 2, t2, "k2_alarm", pk(A_BCD, 6'h00, 2'd1, 1'b0));
      push_run(t2 + 1, t2 + 20, "k2_sw", pk(S_BCD, 6'h00, 2'd2, 1'b0));
      pulse_key();
      step(t2 - 1 - cyc);
      pulse_key();
      step(t2 + 20 - cyc);
      j = cyc;
      push(j + 1, "sw_last", pk(S_BCD, 6'h00, 2'd2, 1'b0));
      push_run(j + 2, j + 4, "sw_to_time", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      pulse_key(); step(3);

      // Edit alarm digit 2, then switch to digit 5 during a visible phase
      k = cyc;
      push(k + 1, "edit_pre", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      edit_req = 1'b1; edit_sel = 1'b1; edit_digit = 3'd2;
      bl_base = k + 1;
      for (int e = k + 2; e <= k + 10; e++)
         push(e, "edit_d2", pk(A_BCD, emask(2, hid(e - 1)), 2'd3, 1'b1));
      step(10);
      edit_digit = 3'd5;
      push(k + 11, "edit_chg", pk(A_BCD, emask(5, hid(k + 10)), 2'd3, 1'b1));
      bl_base = k + 11;
      for (int e = k + 12; e <= k + 21; e++)
         push(e, "edit_d5", pk(A_BCD, emask(5, hid(e - 1)), 2'd3, 1'b1));
      step(11);

      // Alarm ring overrides edit, and edit resumes when the ring stops
      r = cyc;
      push(r + 1, "ring_pre", pk(A_BCD, emask(5, hid(r)), 2'd3, 1'b1));
      alarm_ring = 1'b1;
      bl_base = r + 1;
      for (int e = r + 2; e <= r + 13; e++)
         push(e, "ring", pk(T_BCD, hid(e - 1) ? 6'h3F : 6'h00, 2'd3, 1'b0));
      step(12);
      alarm_ring = 1'b0;
      bl_base = r + 13;
      for (int e = r + 14; e <= r + 21; e++)
         push(e, "ring_to_edit", pk(A_BCD, emask(5, hid(e - 1)), 2'd3, 1'b1));
      step(9);
      edit_req = 1'b0;
      push(r + 22, "edit_last", pk(A_BCD, emask(5, hid(r + 21)), 2'd3, 1'b1));
      push_run(r + 23, r + 26, "edit_exit", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      step(5);

      // Key and edit request together: edit wins, key dropped; digit 6 never blanks
      s = cyc;
      push(s + 1, "sim_pre", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      key_view = 1'b1; edit_req = 1'b1; edit_sel = 1'b0; edit_digit = 3'd6;
      bl_base = s + 1;
      push_run(s + 2, s + 11, "sim_edit", pk(T_BCD, 6'h00, 2'd3, 1'b1));
      step(1); key_view = 1'b0; step(9);
      edit_req = 1'b0;
      push_run(s + 12, s + 17, "sim_exit", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      step(7);

      // BCD pass-through with one cycle of latency
      time_bcd = 24'h235959;
      push_run(cyc + 1, cyc + 3, "bcd_pass", pk(24'h235959, 6'h00, 2'd0, 1'b0));
      step(3);
      time_bcd = T_BCD;
      push(cyc + 1, "bcd_back", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      step(1);

      // Asynchronous reset in the middle of the alarm view
      m = cyc;
      push_run(m + 2, m + 4, "pre_rst_alarm", pk(A_BCD, 6'h00, 2'd1, 1'b0));
      pulse_key(); step(3);
      #5;
      rst_n = 1'b0;
      #1;
      chk("rst_mid", {data, blank, view, edit_ack}, 33'h0);
      step(2);
      rst_n = 1'b1;
      m = cyc;
      push_run(m + 2, m + 3, "rst_release", pk(T_BCD, 6'h00, 2'd0, 1'b0));
      step(4);
      chk("sb_drain", 33'(sb_q.size()), 33'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
